// File: rtl/v_sel_rr_arbiter.sv
// v_sel_rr_arbiter: registered round-robin select generator for a 3-to-8 decoder.
// Skips index 1, bounds each grant to HOLD enabled cycles and forces one idle gap after each grant.
module v_sel_rr_arbiter #(
    parameter int HOLD = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] req,
    output logic [2:0] sel,
    output logic       valid,
    output logic       done
);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

    state_t     r_state;
    logic [2:0] r_last;
    logic [3:0] r_cnt;
    logic [2:0] r_sel;
    logic       r_valid;
    logic       r_done;

    state_t     w_state;
    logic [2:0] w_last;
    logic [3:0] w_cnt;
    logic [2:0] w_sel;
    logic       w_valid;
    logic       w_done;

    logic [7:0] w_mreq;
    logic [2:0] w_cand;
    logic [2:0] w_pick;
    logic       w_found;
    logic       w_end;

    // Decoder output 1 is unused, so its request never competes.
    assign w_mreq = req & 8'b1111_1101;

    // Circular priority search starting just after the last granted index.
    always_comb begin
        w_found = 1'b0;
        w_pick  = 3'd0;
        w_cand  = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            w_cand = r_last + 3'(k);
            if (!w_found && w_mreq[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    // A grant ends on tenure expiry or when its own request drops.
    assign w_end = (r_cnt == 4'd0) || !req[r_sel];

    // Next-state and output decode; done is a single-cycle pulse by default.
    always_comb begin
        w_state = r_state;
        w_last  = r_last;
        w_cnt   = r_cnt;
        w_sel   = r_sel;
        w_valid = r_valid;
        w_done  = 1'b0;
        if (en) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        w_sel   = w_pick;
                        w_valid = 1'b1;
                        w_cnt   = HOLD_M1;
                        w_state = ST_GRANT;
                    end else begin
                        w_valid = 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (w_end) begin
                        w_valid = 1'b0;
                        w_done  = 1'b1;
                        w_last  = r_sel;
                        w_state = ST_IDLE;
                    end else begin
                        w_cnt = r_cnt - 4'd1;
                    end
                end
                default: begin
                    w_state = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers; clr wipes everything immediately.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_last  <= 3'b111;
            r_cnt   <= 4'd0;
            r_sel   <= 3'b000;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_last  <= w_last;
            r_cnt   <= w_cnt;
            r_sel   <= w_sel;
            r_valid <= w_valid;
            r_done  <= w_done;
        end
    end

    assign sel   = r_sel;
    assign valid = r_valid;
    assign done  = r_done;

endmodule

// File: tb/tb_v_sel_rr_arbiter.sv
// tb_v_sel_rr_arbiter: scenario tasks plus randomized traffic against a
// behavioural round-robin model with tenure counted in valid cycles.
module tb_v_sel_rr_arbiter;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       en = 1'b1;
    logic [7:0] req = 8'h00;
    logic [2:0] sel;
    logic       valid;
    logic       done;

    int checks = 0;
    int failures = 0;

    // behavioural model
    int         m_last;
    int         m_used;
    logic [2:0] m_sel;
    logic       m_valid;
    logic       m_done;

    int exp_seq [8] = '{0, 2, 3, 4, 5, 6, 7, 0};

    v_sel_rr_arbiter #(.HOLD(HOLD)) dut (
        .clk  (clk),
        .clr  (clr),
        .en   (en),
        .req  (req),
        .sel  (sel),
        .valid(valid),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_last  = 7;
        m_used  = 0;
        m_sel   = 3'd0;
        m_valid = 1'b0;
        m_done  = 1'b0;
    endtask

    task automatic model_edge();
        int c;
        bit hit;
        if (!en) begin
            m_done = 1'b0;
        end else if (!m_valid) begin
            m_done = 1'b0;
            hit = 0;
            for (int k = 1; k <= 8; k++) begin
                c = (m_last + k) % 8;
                if (!hit && c != 1 && req[c]) begin
                    hit = 1;
                    m_sel = 3'(c);
                end
            end
            if (hit) begin
                m_valid = 1'b1;
                m_used  = 1;
            end
        end else if (m_used >= HOLD || !req[m_sel]) begin
            m_valid = 1'b0;
            m_done  = 1'b1;
            m_last  = int'(m_sel);
        end else begin
            m_used++;
            m_done = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        #2;
        model_reset();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        req = 8'hFF;
        en  = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if ({sel, valid, done} !== 5'b000_0_0) begin
            failures++;
            $display("FAIL reset_hold got sel=%0d v=%b d=%b want 0 0 0", sel, valid, done);
        end
        clr = 1'b0;
        step();
        checks++;
        if (sel !== 3'd0 || valid !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_grant got sel=%0d v=%b d=%b want 0 1 0", sel, valid, done);
        end
    endtask

    task automatic test_round_robin();
        int ng;
        int run;
        logic pv;
        do_reset();
        en  = 1'b1;
        req = 8'hFF;
        ng  = 0;
        run = 0;
        pv  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if (sel !== m_sel || valid !== m_valid || done !== m_done || sel === 3'd1) begin
                failures++;
                $display("FAIL rr_cycle%0d got %0d/%b/%b want %0d/%b/%b",
                         i, sel, valid, done, m_sel, m_valid, m_done);
            end
            if (valid && !pv) begin
                checks++;
                if (ng < 8 && int'(sel) !== exp_seq[ng]) begin
                    failures++;
                    $display("FAIL rr_seq%0d got sel=%0d want %0d", ng, sel, exp_seq[ng]);
                end
                ng++;
                run = 0;
            end
            if (valid) run++;
            if (done) begin
                checks++;
                if (run !== HOLD) begin
                    failures++;
                    $display("FAIL rr_tenure got %0d want %0d", run, HOLD);
                end
            end
            pv = valid;
        end
        checks++;
        if (ng !== 8) begin
            failures++;
            $display("FAIL rr_grant_count got %0d want 8", ng);
        end
    endtask

    task automatic test_index1_only();
        do_reset();
        en  = 1'b1;
        req = 8'h02;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (sel !== 3'd0 || valid !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL idx1_cycle%0d got %0d/%b/%b want 0/0/0", i, sel, valid, done);
            end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        en  = 1'b1;
        req = 8'h10;
        step();
        step();
        checks++;
        if (sel !== 3'd4 || valid !== 1'b1) begin
            failures++;
            $display("FAIL early_grant got sel=%0d v=%b want 4 1", sel, valid);
        end
        req = 8'h00;
        step();
        checks++;
        if (valid !== 1'b0 || done !== 1'b1 || sel !== m_sel) begin
            failures++;
            $display("FAIL early_release got v=%b d=%b want 0 1", valid, done);
        end
        req = 8'h10;
        step();
        checks++;
        if (sel !== 3'd4 || valid !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL early_regrant got %0d/%b/%b want 4/1/0", sel, valid, done);
        end
    endtask

    task automatic test_enable_stall();
        int vc;
        bit seen;
        do_reset();
        en  = 1'b1;
        req = 8'h08;
        vc  = 0;
        seen = 0;
        step();
        if (valid) vc++;
        step();
        if (valid) vc++;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (valid) vc++;
            checks++;
            if (done !== 1'b0 || valid !== m_valid) begin
                failures++;
                $display("FAIL stall_frozen%0d got v=%b d=%b want %b 0", i, valid, done, m_valid);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (done) seen = 1;
            else if (valid) vc++;
        end
        checks++;
        if (!seen || vc !== 7) begin
            failures++;
            $display("FAIL stall_tenure got valid_cycles=%0d done_seen=%0d want 7 1", vc, seen);
        end
        req = 8'h00;
        step();
        checks++;
        if (done !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_single_done got v=%b d=%b want 0 0", valid, done);
        end
    endtask

    task automatic test_clear_mid_grant();
        do_reset();
        en  = 1'b1;
        req = 8'h40;
        step();
        step();
        checks++;
        if (sel !== 3'd6 || valid !== 1'b1) begin
            failures++;
            $display("FAIL clr_pre got sel=%0d v=%b want 6 1", sel, valid);
        end
        #2;
        clr = 1'b1;
        #1;
        model_reset();
        checks++;
        if (sel !== 3'd0 || valid !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL clr_async got %0d/%b/%b want 0/0/0", sel, valid, done);
        end
        #2;
        clr = 1'b0;
        req = 8'h41;
        step();
        checks++;
        if (sel !== 3'd0 || valid !== 1'b1 || sel !== m_sel) begin
            failures++;
            $display("FAIL clr_first_grant got sel=%0d v=%b want 0 1", sel, valid);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom());
            en = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 99) == 0) begin
                clr = 1'b1;
                #1;
                model_reset();
                clr = 1'b0;
            end
            step();
            checks++;
            if (sel !== m_sel || valid !== m_valid || done !== m_done
                || sel === 3'd1 || (valid && done)) begin
                failures++;
                $display("FAIL rand_cycle%0d got %0d/%b/%b want %0d/%b/%b",
                         i, sel, valid, done, m_sel, m_valid, m_done);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_round_robin();
        test_index1_only();
        test_early_release();
        test_enable_stall();
        test_clear_mid_grant();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
